// File: rtl/dbus_sram_resp.sv
// Data-bus responder backed by a synchronous single-port RAM. Decodes one
// address window, inserts WAIT_CYC wait states, and drives OR-bus friendly read data.
module dbus_sram_resp #(
    parameter logic [31:0] BASE     = 32'h0001_0000,
    parameter int          AW       = 12,
    parameter int          WAIT_CYC = 0
) (
    input  logic        cclk,
    input  logic        xreset,
    input  logic [31:0] adr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        rdy
);

    // Handshake: a selected request (re or any we bit) is accepted on the
    // rising edge where rdy=1; while rdy=0 the core holds adr/we/re/dw
    // stable. Dropping the request before acceptance cancels it silently.
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYC);

    logic          sel;
    logic          req;
    logic          at_lim;
    logic          commit;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] idx;
    logic [3:0]    cnt;
    logic          own;
    logic [31:0]   rdata;
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          unused_adr;

    assign sel        = (adr[31:AW+2] == BASE[31:AW+2]);
    assign req        = sel & (re | (we != 4'b0000));
    assign idx        = adr[AW+1:2];
    assign at_lim     = (cnt == WAIT_LIM);
    assign commit     = req & at_lim;
    assign wr_en      = xreset & commit & (we != 4'b0000);
    assign rd_en      = commit & (we == 4'b0000);
    assign rdy        = !req | at_lim;
    assign dr         = own ? rdata : 32'h0;
    // Lane selection comes only from we; the low address bits carry no meaning.
    assign unused_adr = ^adr[1:0];

    always_ff @(posedge cclk) begin
        if (!xreset) begin
            cnt <= 4'd0;
        end else if (req && !at_lim) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= 4'd0;
        end
    end

    // RAM array has no reset so it maps onto block RAM.
    always_ff @(posedge cclk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && we[i]) begin
                mem[idx][8*i +: 8] <= dw[8*i +: 8];
            end
        end
    end

    // A read elsewhere on the bus hands dr ownership away so another
    // responder's data is not corrupted by the OR.
    always_ff @(posedge cclk) begin
        if (!xreset) begin
            rdata <= 32'h0;
            own   <= 1'b0;
        end else if (rd_en) begin
            rdata <= mem[idx];
            own   <= 1'b1;
        end else if (re && !sel) begin
            own   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbus_sram_resp.sv
// Directed bench for dbus_sram_resp: three instances with different wait
// counts share one bus, reads are predicted from a RAM model and scoreboarded.
module tb_dbus_sram_resp;

    localparam logic [31:0] B0 = 32'h0001_0000;
    localparam logic [31:0] B2 = 32'h0002_0000;
    localparam logic [31:0] B3 = 32'h0003_0000;

    logic        cclk;
    logic        xreset;
    logic [31:0] adr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dw;
    logic [31:0] dr0, dr2, dr3;
    logic        rdy0, rdy2, rdy3;
    logic [31:0] dr_bus;
    logic        rdy_all;

    logic [31:0] exp_q[$];
    logic [31:0] model_mem [logic [31:0]];
    int          n_assert;
    int          n_fail;

    assign dr_bus  = dr0 | dr2 | dr3;
    assign rdy_all = rdy0 & rdy2 & rdy3;

    dbus_sram_resp #(.BASE(B0), .AW(12), .WAIT_CYC(0)) u_w0 (
        .cclk(cclk), .xreset(xreset), .adr(adr), .we(we), .re(re), .dw(dw),
        .dr(dr0), .rdy(rdy0)
    );
    dbus_sram_resp #(.BASE(B2), .AW(12), .WAIT_CYC(2)) u_w2 (
        .cclk(cclk), .xreset(xreset), .adr(adr), .we(we), .re(re), .dw(dw),
        .dr(dr2), .rdy(rdy2)
    );
    dbus_sram_resp #(.BASE(B3), .AW(12), .WAIT_CYC(3)) u_w3 (
        .cclk(cclk), .xreset(xreset), .adr(adr), .we(we), .re(re), .dw(dw),
        .dr(dr3), .rdy(rdy3)
    );

    // Clock / watchdog
    initial begin
        cclk = 1'b0;
        forever #5 cclk = ~cclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (model_mem.exists(wa)) return model_mem[wa];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [3:0] lanes, input logic [31:0] d);
        logic [31:0] wa;
        logic [31:0] v;
        wa = {a[31:2], 2'b00};
        v  = model_mem.exists(wa) ? model_mem[wa] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) v[8*i +: 8] = d[8*i +: 8];
        end
        model_mem[wa] = v;
    endtask

    // Driver tasks: inputs change 1 time unit after the edge, rdy is sampled
    // once they have settled, dr one unit after the accepting edge.
    task automatic do_write(input logic [31:0] a, input logic [3:0] lanes,
                            input logic [31:0] d, input int waits, input string tag);
        adr = a; we = lanes; dw = d; re = 1'b0;
        for (int c = 0; c < waits; c++) begin
            #1; chk({tag, "_rdy_wait"}, {31'b0, rdy_all}, 32'd0);
            tick();
        end
        #1; chk({tag, "_rdy_commit"}, {31'b0, rdy_all}, 32'd1);
        tick();
        model_wr(a, lanes, d);
        we = 4'b0000; dw = 32'h0; adr = 32'h0;
    endtask

    task automatic do_read(input logic [31:0] a, input int waits, input string tag);
        logic [31:0] e;
        adr = a; re = 1'b1; we = 4'b0000;
        for (int c = 0; c < waits; c++) begin
            #1; chk({tag, "_rdy_wait"}, {31'b0, rdy_all}, 32'd0);
            tick();
        end
        #1; chk({tag, "_rdy_commit"}, {31'b0, rdy_all}, 32'd1);
        exp_q.push_back(model_rd(a));
        tick();
        re = 1'b0; adr = 32'h0;
        #1;
        e = exp_q.pop_front();
        chk({tag, "_dr"}, dr_bus, e);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        xreset = 1'b0; adr = B0; we = 4'b0000; re = 1'b1; dw = 32'h0;

        // Reset with a read pending at BASE: no ownership may be taken.
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("reset_dr", dr_bus, 32'h0);
        end
        xreset = 1'b1; re = 1'b0; adr = 32'h0;
        #1; chk("reset_rdy", {31'b0, rdy_all}, 32'd1);
        tick();
        chk("reset_no_own", dr_bus, 32'h0);

        // Zero-wait full word and byte lane accesses
        do_write(B0 + 32'h8, 4'hF, 32'hDEAD_BEEF, 0, "w0_full_wr");
        do_read (B0 + 32'h8, 0, "w0_full_rd");
        do_write(B0 + 32'h8, 4'b0100, 32'h0055_0000, 0, "w0_lane_wr");
        do_read (B0 + 32'h8, 0, "w0_lane_rd");
        chk("w0_lane_value", dr0, 32'hDE55_BEEF);

        // Two wait states
        do_write(B2 + 32'h4, 4'hF, 32'h1234_5678, 2, "w2_wr");
        do_read (B2 + 32'h4, 2, "w2_rd");
        chk("w2_value", dr2, 32'h1234_5678);
        // Write held only for the wait cycles: must not reach memory.
        adr = B2 + 32'h4; we = 4'hF; dw = 32'hCAFE_F00D;
        tick(); tick();
        we = 4'b0000; dw = 32'h0; adr = 32'h0;
        tick();
        do_read (B2 + 32'h4, 2, "w2_early_rd");
        do_write(B2 + 32'h4, 4'hF, 32'hCAFE_F00D, 2, "w2_wr2");
        do_read (B2 + 32'h4, 2, "w2_rd2");

        // Three wait states: abort after one cycle
        do_write(B3 + 32'h10, 4'hF, 32'h0BAD_CAFE, 3, "w3_wr");
        adr = B3 + 32'h10; we = 4'hF; dw = 32'h5555_AAAA;
        #1; chk("w3_abort_rdy0", {31'b0, rdy_all}, 32'd0);
        tick();
        we = 4'b0000; dw = 32'h0; adr = 32'h0;
        #1; chk("w3_abort_rdy_idle", {31'b0, rdy_all}, 32'd1);
        tick();
        do_read (B3 + 32'h10, 3, "w3_abort_rd");

        // Reset mid-wait discards the pending write
        adr = B3 + 32'h10; we = 4'hF; dw = 32'hFFFF_FFFF;
        tick(); tick();
        xreset = 1'b0;
        #1; chk("w3_rst_rdy_pend", {31'b0, rdy_all}, 32'd0);
        tick();
        xreset = 1'b1; we = 4'b0000; dw = 32'h0; adr = 32'h0;
        #1; chk("w3_rst_rdy_idle", {31'b0, rdy_all}, 32'd1);
        chk("w3_rst_dr", dr_bus, 32'h0);
        tick();
        do_read (B3 + 32'h10, 3, "w3_rst_rd");

        // OR-bus ownership and window boundaries
        do_write(B0, 4'hF, 32'hA5A5_A5A5, 0, "or_wr");
        do_write(B0 + 32'h3FFC, 4'hF, 32'h1111_2222, 0, "top_wr");
        do_read (B0, 0, "or_rd");
        adr = B0 - 32'h4; re = 1'b1;
        #1; chk("foreign_rdy", {31'b0, rdy_all}, 32'd1);
        tick();
        re = 1'b0; adr = 32'h0;
        #1; chk("foreign_dr", dr_bus, 32'h0);
        chk("foreign_dr0", dr0, 32'h0);
        // Unselected writes just outside both ends of the window
        adr = B0 - 32'h4; we = 4'hF; dw = 32'h0;
        #1; chk("below_wr_rdy", {31'b0, rdy_all}, 32'd1);
        tick();
        adr = B0 + 32'h4000;
        #1; chk("above_wr_rdy", {31'b0, rdy_all}, 32'd1);
        tick();
        we = 4'b0000; adr = 32'h0;
        tick();
        do_read (B0, 0, "or_rd_again");
        do_read (B0 + 32'h3FFC, 0, "top_rd");

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
